// File: rtl/x_uart_arb_pkg.sv
// Shared types and constants for the x_uart_tx arbiter.
package x_uart_arb_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/x_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo p_n.
module x_rr_pick #(
   parameter int p_n = 4,
   parameter int PW  = $clog2(p_n)
) (
   input  logic [p_n-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [p_n-1:0] pick,
   output logic           any
);

   int   idx_s;
   logic found_s;

   // Scan p_n positions starting at ptr; the wrap is an explicit subtract so odd p_n works.
   always_comb begin
      pick    = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int i = 0; i < p_n; i++) begin
         idx_s = int'(ptr) + i;
         if (idx_s >= p_n) begin
            idx_s = idx_s - p_n;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s]) begin
            pick[idx_s] = 1'b1;
            found_s     = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/x_uart_tx_arb.sv
// Packet-locking round-robin arbiter sharing one x_uart_tx between p_n requesters.
// Optional idle-timeout release is built when X_UART_TX_ARB_TIMEOUT_EN is defined.
module x_uart_tx_arb
   import x_uart_arb_pkg::*;
#(
   parameter int p_n       = 4,
   parameter int p_timeout = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [p_n-1:0]        i_req_valid,
   input  logic [BYTE_W*p_n-1:0] i_req_data,
   input  logic [p_n-1:0]        i_req_last,
   output logic [p_n-1:0]        o_req_accept,
   output logic                  o_tx_valid,
   output logic [BYTE_W-1:0]     o_tx_data,
   input  logic                  i_tx_accept,
   output logic [p_n-1:0]        o_grant,
   output logic                  o_busy,
   output logic                  o_timeout
);

   localparam int PW = $clog2(p_n);
   localparam logic [PW-1:0] LAST_IDX = PW'(p_n - 1);

   arb_state_e        state_r;
   logic [p_n-1:0]    grant_r;
   logic [PW-1:0]     gidx_r;
   logic [PW-1:0]     rr_ptr_r;
   logic              busy_r;
   logic              timeout_r;

   logic [p_n-1:0]    pick_s;
   logic              any_s;
   logic [PW-1:0]     pick_idx_s;
   logic [PW-1:0]     next_ptr_s;
   logic [BYTE_W-1:0] tx_data_s;
   logic              tx_valid_s;
   logic              last_s;
   logic              xfer_s;

`ifdef X_UART_TX_ARB_TIMEOUT_EN
   // Counter only has to reach p_timeout-2: expiry fires as it would step to p_timeout-1.
   localparam int TW = (p_timeout > 2) ? $clog2(p_timeout) : 1;
   localparam logic [TW-1:0] TO_LIM = TW'(p_timeout - 2);
   logic [TW-1:0] to_cnt_r;
`endif

   x_rr_pick #(.p_n(p_n), .PW(PW)) u_pick (
      .req  (i_req_valid),
      .ptr  (rr_ptr_r),
      .pick (pick_s),
      .any  (any_s)
   );

   // Grant-steered byte mux and one-hot index encode; grant is zero in IDLE so outputs read zero.
   always_comb begin
      tx_data_s  = '0;
      pick_idx_s = '0;
      for (int k = 0; k < p_n; k++) begin
         if (grant_r[k]) begin
            tx_data_s = i_req_data[k*BYTE_W +: BYTE_W];
         end else begin
            tx_data_s = tx_data_s;
         end
         if (pick_s[k]) begin
            pick_idx_s = PW'(k);
         end else begin
            pick_idx_s = pick_idx_s;
         end
      end
   end

   assign tx_valid_s = |(grant_r & i_req_valid);
   assign last_s     = |(grant_r & i_req_last);
   assign xfer_s     = tx_valid_s & i_tx_accept;
   assign next_ptr_s = (gidx_r == LAST_IDX) ? '0 : gidx_r + 1'b1;

   // Arbitration FSM, round-robin pointer and optional idle-timeout counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r   <= ARB_IDLE;
         grant_r   <= '0;
         gidx_r    <= '0;
         rr_ptr_r  <= '0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
`ifdef X_UART_TX_ARB_TIMEOUT_EN
         to_cnt_r  <= '0;
`endif
      end else begin
         timeout_r <= 1'b0;
         case (state_r)
            ARB_IDLE: begin
               if (any_s) begin
                  state_r <= ARB_LOCKED;
                  grant_r <= pick_s;
                  gidx_r  <= pick_idx_s;
                  busy_r  <= 1'b1;
`ifdef X_UART_TX_ARB_TIMEOUT_EN
                  to_cnt_r <= '0;
`endif
               end else begin
                  state_r <= ARB_IDLE;
               end
            end
            ARB_LOCKED: begin
               if (xfer_s) begin
                  if (last_s) begin
                     state_r  <= ARB_IDLE;
                     grant_r  <= '0;
                     busy_r   <= 1'b0;
                     rr_ptr_r <= next_ptr_s;
                  end else begin
                     state_r  <= ARB_LOCKED;
                  end
`ifdef X_UART_TX_ARB_TIMEOUT_EN
                  to_cnt_r <= '0;
`endif
               end else begin
`ifdef X_UART_TX_ARB_TIMEOUT_EN
                  if (!tx_valid_s) begin
                     if (to_cnt_r == TO_LIM) begin
                        state_r   <= ARB_IDLE;
                        grant_r   <= '0;
                        busy_r    <= 1'b0;
                        rr_ptr_r  <= next_ptr_s;
                        timeout_r <= 1'b1;
                     end else begin
                        to_cnt_r  <= to_cnt_r + 1'b1;
                     end
                  end else begin
                     to_cnt_r <= to_cnt_r;
                  end
`else
                  state_r <= ARB_LOCKED;
`endif
               end
            end
            default: begin
               state_r <= ARB_IDLE;
               grant_r <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx_valid   = tx_valid_s;
   assign o_tx_data    = tx_data_s;
   assign o_req_accept = grant_r & {p_n{xfer_s}};
   assign o_grant      = grant_r;
   assign o_busy       = busy_r;
   assign o_timeout    = timeout_r;

endmodule

// File: tb/tb_x_uart_tx_arb.sv
// Scoreboard bench for x_uart_tx_arb (p_n=4, p_timeout=8); timeout scenario follows X_UART_TX_ARB_TIMEOUT_EN.
module tb_x_uart_tx_arb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_accept;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_accept;
   logic [3:0]  grant;
   logic        busy;
   logic        timeout;

   x_uart_tx_arb #(.p_n(4), .p_timeout(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_data   (req_data),
      .i_req_last   (req_last),
      .o_req_accept (req_accept),
      .o_tx_valid   (tx_valid),
      .o_tx_data    (tx_data),
      .i_tx_accept  (tx_accept),
      .o_grant      (grant),
      .o_busy       (busy),
      .o_timeout    (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;
   int xfer_cnt = 0;

   // Per-requester byte sources and the expected {requester, byte} transfer order.
   logic [7:0]  src_data [4][16];
   logic        src_last [4][16];
   int          src_len  [4];
   int          src_pos  [4];
   logic [3:0]  acc_r;
   logic        rand_acc;
   logic [11:0] exp_q [$];
   logic [11:0] e;
   logic [3:0]  one_hot;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_only();
      for (int k = 0; k < 4; k++) begin
         if (src_pos[k] < src_len[k]) begin
            req_valid[k]       = 1'b1;
            req_data[8*k +: 8] = src_data[k][src_pos[k]];
            req_last[k]        = src_last[k][src_pos[k]];
         end else begin
            req_valid[k]       = 1'b0;
            req_data[8*k +: 8] = 8'h00;
            req_last[k]        = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (acc_r[k] === 1'b1 && src_pos[k] < src_len[k]) src_pos[k]++;
      end
      drive_only();
      tx_accept = rand_acc ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic load(input int k, input int n, input logic [7:0] base, input logic last_at_end);
      for (int i = 0; i < n; i++) begin
         src_data[k][src_len[k]] = base + 8'(i);
         src_last[k][src_len[k]] = last_at_end && (i == n - 1);
         src_len[k]++;
      end
      drive_only();
   endtask

   task automatic push_exp(input int k, input logic [7:0] d);
      exp_q.push_back({4'(k), d});
   endtask

   task automatic clear_src();
      for (int k = 0; k < 4; k++) begin
         src_len[k] = 0;
         src_pos[k] = 0;
      end
      drive_only();
   endtask

   task automatic wait_drain(input int budget, input string tag);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
      check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      clear_src();
      exp_q.delete();
      tx_accept = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Transfer monitor: every valid&accept pops the scoreboard and must match grant, byte and accept pulse.
   always @(negedge clk) begin
      acc_r = req_accept;
      if (tx_valid === 1'b1 && tx_accept === 1'b1) begin
         xfer_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("sb_extra", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            one_hot = 4'b0001 << e[9:8];
            check_eq("grant", 32'(grant), 32'(one_hot));
            check_eq("data", 32'(tx_data), 32'(e[7:0]));
            check_eq("accept", 32'(req_accept), 32'(one_hot));
         end
      end else if (tx_accept === 1'b1) begin
         check_eq("acc_idle", 32'(req_accept), 32'd0);
      end
   end

   initial begin
      int start;
      int c;
      logic any_to;
      rst_n = 1'b0;
      tx_accept = 1'b0;
      rand_acc = 1'b0;
      acc_r = 4'b0000;
      req_valid = 4'b0000;
      req_data = 32'h0;
      req_last = 4'b0000;
      clear_src();
      repeat (3) step();
      tx_accept = 1'b0;
      @(negedge clk);
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);
      check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_eq("rst_req_accept", 32'(req_accept), 32'd0);
      check_eq("rst_tx_data", 32'(tx_data), 32'd0);
      rst_n = 1'b1;

      // Single requester 2, three-byte packet; then rr_ptr=3 means requester 3 beats 0.
      load(2, 3, 8'h41, 1'b1);
      push_exp(2, 8'h41);
      push_exp(2, 8'h42);
      push_exp(2, 8'h43);
      wait_drain(50, "t1");
      @(negedge clk);
      check_eq("t1_idle_busy", 32'(busy), 32'd0);
      check_eq("t1_idle_grant", 32'(grant), 32'd0);
      load(0, 1, 8'hA0, 1'b1);
      load(3, 1, 8'hA3, 1'b1);
      push_exp(3, 8'hA3);
      push_exp(0, 8'hA0);
      wait_drain(50, "t1_rr");

      // All four continuously valid with single-byte packets: strict rotation from 0.
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) begin
            load(k, 1, 8'(16 * (k + 1) + r), 1'b1);
            push_exp(k, 8'(16 * (k + 1) + r));
         end
      end
      wait_drain(200, "t2");

      // Interleave guard with random transmitter back-pressure.
      do_reset();
      rand_acc = 1'b1;
      load(1, 2, 8'hB0, 1'b1);
      load(0, 4, 8'hC0, 1'b1);
      for (int i = 0; i < 4; i++) push_exp(0, 8'hC0 + 8'(i));
      push_exp(1, 8'hB0);
      push_exp(1, 8'hB1);
      wait_drain(400, "t3");
      rand_acc = 1'b0;

      // Mid-packet reset: rr_ptr is 2 here, so a stale pointer would favour requester 3.
      load(0, 4, 8'hD0, 1'b1);
      for (int i = 0; i < 4; i++) push_exp(0, 8'hD0 + 8'(i));
      start = xfer_cnt;
      for (int i = 0; i < 50 && (xfer_cnt - start) < 2; i++) step();
      check_eq("t4_two_bytes", 32'(xfer_cnt - start), 32'd2);
      clear_src();
      exp_q.delete();
      tx_accept = 1'b0;
      rst_n = 1'b0;
      step();
      @(negedge clk);
      check_eq("t4_grant", 32'(grant), 32'd0);
      check_eq("t4_busy", 32'(busy), 32'd0);
      check_eq("t4_tx_valid", 32'(tx_valid), 32'd0);
      rst_n = 1'b1;
      load(3, 1, 8'hE3, 1'b1);
      load(0, 1, 8'hE0, 1'b1);
      push_exp(0, 8'hE0);
      push_exp(3, 8'hE3);
      wait_drain(50, "t4");

      // Requester 1 sends one non-last byte then drops valid while requester 3 waits.
      load(1, 1, 8'h55, 1'b0);
      push_exp(1, 8'h55);
      wait_drain(50, "t5_byte");
      load(3, 1, 8'h77, 1'b1);
`ifdef X_UART_TX_ARB_TIMEOUT_EN
      c = 0;
      while (c < 31) begin
         @(negedge clk);
         if (timeout === 1'b1) break;
         step();
         c++;
      end
      check_eq("t5_to_delay", 32'(c), 32'd7);
      check_eq("t5_to_busy", 32'(busy), 32'd0);
      push_exp(3, 8'h77);
      wait_drain(50, "t5_next");
      @(negedge clk);
      check_eq("t5_to_single", 32'(timeout), 32'd0);
`else
      c = 0;
      any_to = 1'b0;
      repeat (20) begin
         step();
         @(negedge clk);
         if (timeout !== 1'b0) any_to = 1'b1;
         c++;
      end
      check_eq("t5_no_timeout", 32'(any_to), 32'd0);
      check_eq("t5_busy_held", 32'(busy), 32'd1);
      check_eq("t5_grant_held", 32'(grant), 32'h2);
`endif
      do_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
